// File: rtl/rv_regfile_mp_pkg.sv
// Shared types and constants for the multi-port decode register file.
package rv_regfile_mp_pkg;

    localparam int unsigned RF_NUM_REGS_DEF = 32;
    localparam int unsigned RF_AW           = $clog2(RF_NUM_REGS_DEF);

    typedef logic [RF_AW-1:0] t_rf_addr;

    localparam t_rf_addr RF_X0 = '0;

endpackage

// File: rtl/rv_rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register plus per-port hazard lookup.
module rv_rf_scoreboard
    import rv_regfile_mp_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned NUM_WR   = 1,
    parameter int unsigned AW       = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      issue_en,
    input  logic [AW-1:0]             issue_rd,
    input  logic                      sb_clr,
    input  logic [NUM_WR-1:0]         wr_en,
    input  logic [NUM_WR-1:0][AW-1:0] wr_addr,
    input  logic [NUM_RD-1:0]         rd_en,
    input  logic [NUM_RD-1:0][AW-1:0] rd_addr,
    input  logic [NUM_RD-1:0]         bypass_hit,
    output logic [NUM_RD-1:0]         rd_hazard
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Priority low to high: write-back clear, new producer set, global flush clear.
    always_comb begin
        busy_d = busy_q;
        for (int unsigned r = 1; r < NUM_REGS; r++) begin
            for (int unsigned j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && (wr_addr[j] == AW'(r))) begin
                    busy_d[r] = 1'b0;
                end
            end
            if (issue_en && (issue_rd == AW'(r))) begin
                busy_d[r] = 1'b1;
            end
            if (sb_clr) begin
                busy_d[r] = 1'b0;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rd_hazard = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            rd_hazard[i] = rd_en[i] && (rd_addr[i] != AW'(RF_X0))
                           && busy_q[rd_addr[i]] && !bypass_hit[i];
        end
    end

endmodule

// File: rtl/rv_regfile_mp.sv
// Multi-port integer register file with write-to-read bypass, busy scoreboard and a
// stall/flush-aware read pipeline register toward execute.
module rv_regfile_mp
    import rv_regfile_mp_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned NUM_WR   = 1,
    localparam int unsigned AW      = $clog2(NUM_REGS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_RD-1:0]           rd_en_Q101H,
    input  logic [NUM_RD-1:0][AW-1:0]   rd_addr_Q101H,
    output logic [NUM_RD-1:0]           rd_hazard_Q101H,
    input  logic [NUM_WR-1:0]           wr_en_Q104H,
    input  logic [NUM_WR-1:0][AW-1:0]   wr_addr_Q104H,
    input  logic [NUM_WR-1:0][XLEN-1:0] wr_data_Q104H,
    input  logic                        issue_en_Q101H,
    input  logic [AW-1:0]               issue_rd_Q101H,
    input  logic                        sb_clr,
    input  logic                        ready_Q102H,
    input  logic                        flush_Q102H,
    output logic [NUM_RD-1:0][XLEN-1:0] rd_data_Q102H,
    output logic [NUM_RD-1:0]           rd_valid_Q102H
);

    logic [NUM_REGS-1:0][XLEN-1:0] regs_q;
    logic [NUM_REGS-1:0][XLEN-1:0] regs_d;
    logic [NUM_RD-1:0][XLEN-1:0]   rd_val;
    logic [NUM_RD-1:0]             bypass_hit;
    logic [NUM_RD-1:0][XLEN-1:0]   rd_data_q;
    logic [NUM_RD-1:0][XLEN-1:0]   rd_data_d;
    logic [NUM_RD-1:0]             rd_valid_q;
    logic [NUM_RD-1:0]             rd_valid_d;

    // Ascending port scan so the youngest (highest index) writer lands last.
    always_comb begin
        regs_d = regs_q;
        for (int unsigned j = 0; j < NUM_WR; j++) begin
            if (wr_en_Q104H[j] && (wr_addr_Q104H[j] != AW'(RF_X0))) begin
                regs_d[wr_addr_Q104H[j]] = wr_data_Q104H[j];
            end
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rd_val     = '0;
        bypass_hit = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            rd_val[i] = regs_q[rd_addr_Q101H[i]];
            for (int unsigned j = 0; j < NUM_WR; j++) begin
                if (wr_en_Q104H[j] && (wr_addr_Q104H[j] == rd_addr_Q101H[i])) begin
                    rd_val[i]     = wr_data_Q104H[j];
                    bypass_hit[i] = 1'b1;
                end
            end
            if (rd_addr_Q101H[i] == AW'(RF_X0)) begin
                rd_val[i]     = '0;
                bypass_hit[i] = 1'b0;
            end
        end
    end

    rv_rf_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD),
        .NUM_WR   (NUM_WR),
        .AW       (AW)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .issue_en   (issue_en_Q101H),
        .issue_rd   (issue_rd_Q101H),
        .sb_clr     (sb_clr),
        .wr_en      (wr_en_Q104H),
        .wr_addr    (wr_addr_Q104H),
        .rd_en      (rd_en_Q101H),
        .rd_addr    (rd_addr_Q101H),
        .bypass_hit (bypass_hit),
        .rd_hazard  (rd_hazard_Q101H)
    );

    // Flush wins over stall so a killed instruction never lingers in Q102H.
    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        if (flush_Q102H) begin
            rd_data_d  = '0;
            rd_valid_d = '0;
        end else if (ready_Q102H) begin
            rd_data_d  = rd_val;
            rd_valid_d = rd_en_Q101H;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= '0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data_Q102H  = rd_data_q;
    assign rd_valid_Q102H = rd_valid_q;

endmodule
